alarm_clock_fsm: RTL

Control sequencer for the digital alarm clock: it turns keypad and push-button activity into the select and load strobes that drive the key buffer, the alarm register, the time counter and the display driver. It sits upstream of the display driver and supplies its `show_a` and `show_new_time` selects. It also guarantees that an abandoned key entry times out and the display returns to current time.

---
 rtl/alarm_clock_fsm.sv | 60 ++++++
 1 files changed

// File: rtl/alarm_clock_fsm.sv
// alarm_clock_fsm: keypad/button sequencer driving key buffer, alarm, time counter and display selects
module alarm_clock_fsm #(
  parameter int unsigned TIMEOUT = 10,
  parameter logic [3:0] NOKEY = 4'hA
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       show_a,
  output logic       show_new_time,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c
);
  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SET_ALARM_TIME   = 3'd4,
    SET_CURRENT_TIME = 3'd5,
    SHOW_ALARM       = 3'd6
  } state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic timeout, key_on, entering;
  assign timeout  = cnt == 4'(TIMEOUT);
  assign key_on   = key != NOKEY;
  assign entering = state == KEY_WAITED || state == KEY_ENTRY;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SHOW_TIME;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= state == KEY_STORED ? 4'd0 : (entering && one_second && !timeout) ? cnt + 4'd1 : cnt;
    end
  end
  // SET_* states and any unused encoding fall through to SHOW_TIME
  always_comb begin
    state_nxt = SHOW_TIME;
    case (state)
      SHOW_TIME:  state_nxt = alarm_button ? SHOW_ALARM : key_on ? KEY_STORED : SHOW_TIME;
      KEY_STORED: state_nxt = KEY_WAITED;
      KEY_WAITED: state_nxt = timeout ? SHOW_TIME : !key_on ? KEY_ENTRY : KEY_WAITED;
      KEY_ENTRY:  state_nxt = alarm_button ? SET_ALARM_TIME : time_button ? SET_CURRENT_TIME :
                              key_on ? KEY_STORED : timeout ? SHOW_TIME : KEY_ENTRY;
      SHOW_ALARM: state_nxt = alarm_button ? SHOW_ALARM : SHOW_TIME;
      default:    state_nxt = SHOW_TIME;
    endcase
  end
  assign show_a        = state == SHOW_ALARM;
  assign show_new_time = entering;
  assign shift         = state == KEY_STORED;
  assign load_new_a    = state == SET_ALARM_TIME;
  assign load_new_c    = state == SET_CURRENT_TIME;
endmodule
